ysyx_22041461_shift_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 64-bit shift unit, covering SLL/SRL/SRA and their 32-bit word forms. It sits between the integer execute stage (port 0) and the address/immediate helper path (port 1), so one shifter serves both. A valid/ready handshake is used on each input. Results go out through a single registered output stage tagged with the winning requester's ID.

---
 rtl/ysyx_22041461_shift_pkg.sv | 26 ++
 rtl/ysyx_22041461_shift_arb_if.sv | 48 ++++
 rtl/ysyx_22041461_shift_core.sv | 49 ++++
 rtl/ysyx_22041461_shift_arb.sv | 107 ++++++++++
 tb/tb_ysyx_22041461_shift_arb.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041461_shift_pkg.sv
// Shared definitions for the shift arbiter slice.
// Contents: shift opcode encodings, requester ID width, shift-amount widths
// for 64-bit and word ops, the result returned for illegal opcodes, and a
// small opcode-decode helper.
package ysyx_22041461_shift_pkg;

  localparam int XLEN     = 64;
  localparam int ID_W     = 1;
  localparam int SHAMT_W  = 6;  // 64-bit ops use src2[5:0]
  localparam int SHAMTW_W = 5;  // word ops use src2[4:0]

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLW = 3'b100;
  localparam logic [2:0] OP_SRLW = 3'b101;
  localparam logic [2:0] OP_SRAW = 3'b110;

  localparam logic [XLEN-1:0] ILLEGAL_RES = '0;

  // Codes x11 are the only holes in the encoding.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/ysyx_22041461_shift_arb_if.sv
// Bundle of the two request ports and the result port of the shift arbiter.
// Handshake rule, identical on every channel: a beat moves on a rising edge
// where valid and ready are both high; the producer keeps valid and payload
// stable from raising valid until that edge; ready never depends on payload.
// Modports:
//   master - requester/consumer side (drives inN_*, out_ready)
//   slave  - arbiter side (drives inN_ready, out_valid/out_res/out_id)
interface ysyx_22041461_shift_arb_if #(
  parameter int DW = 64
);
  import ysyx_22041461_shift_pkg::*;

  logic            in0_valid;
  logic            in0_ready;
  logic [2:0]      in0_op;
  logic [DW-1:0]   in0_src1;
  logic [DW-1:0]   in0_src2;

  logic            in1_valid;
  logic            in1_ready;
  logic [2:0]      in1_op;
  logic [DW-1:0]   in1_src1;
  logic [DW-1:0]   in1_src2;

  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_res;
  logic [ID_W-1:0] out_id;

  modport master (
    output in0_valid, in0_op, in0_src1, in0_src2,
    input  in0_ready,
    output in1_valid, in1_op, in1_src1, in1_src2,
    input  in1_ready,
    input  out_valid, out_res, out_id,
    output out_ready
  );

  modport slave (
    input  in0_valid, in0_op, in0_src1, in0_src2,
    output in0_ready,
    input  in1_valid, in1_op, in1_src1, in1_src2,
    output in1_ready,
    output out_valid, out_res, out_id,
    input  out_ready
  );

endinterface

// File: rtl/ysyx_22041461_shift_core.sv
// Combinational 64-bit shifter covering SLL/SRL/SRA and SLLW/SRLW/SRAW.
// Ports:
//   op   in  3  : opcode (package encoding); x11 yields ILLEGAL_RES
//   src1 in  DW : value to shift (word ops use bits [31:0])
//   src2 in  DW : shift amount source (only low 6 / 5 bits used)
//   res  out DW : result; word results are sign-extended from bit 31
module ysyx_22041461_shift_core
  import ysyx_22041461_shift_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] src1,
  input  logic [DW-1:0] src2,
  output logic [DW-1:0] res
);

  logic [SHAMT_W-1:0]  sh;
  logic [SHAMTW_W-1:0] shw;
  logic [31:0]         w;
  logic [31:0]         w_res;

  // Upper shift-amount bits are ignored by definition.
  logic unused_src2_hi;
  assign unused_src2_hi = ^src2[DW-1:SHAMT_W];

  assign sh  = src2[SHAMT_W-1:0];
  assign shw = src2[SHAMTW_W-1:0];
  assign w   = src1[31:0];

  always_comb begin
    w_res = '0;
    res   = DW'(ILLEGAL_RES);
    case (op)
      OP_SLL:  res   = src1 << sh;
      OP_SRL:  res   = src1 >> sh;
      OP_SRA:  res   = $unsigned($signed(src1) >>> sh);
      OP_SLLW: w_res = w << shw;
      OP_SRLW: w_res = w >> shw;
      OP_SRAW: w_res = $unsigned($signed(w) >>> shw);
      default: ;
    endcase
    // Every legal word op, including the logical ones, sign-extends bit 31.
    if (op[2] && op_is_legal(op)) begin
      res = {{(DW-32){w_res[31]}}, w_res};
    end
  end

endmodule

// File: rtl/ysyx_22041461_shift_arb.sv
// Two-requester arbiter in front of one shared shift unit, with a single
// registered result stage tagged by the winning port.
// Ports:
//   clk          in  1 : clock, rising edge
//   rst_n        in  1 : asynchronous active-low reset
//   bus          slave : in0_*/in1_* request channels, out_* result channel
//   dbg_last_gnt out 1 : arbitration state (port of the last accepted beat)
// Build option:
//   YSYX_22041461_SHARB_RR_EN defined   -> round-robin on ties
//   YSYX_22041461_SHARB_RR_EN undefined -> port 0 always wins ties
module ysyx_22041461_shift_arb
  import ysyx_22041461_shift_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_22041461_shift_arb_if.slave   bus,
  output logic                       dbg_last_gnt
);

  logic            last_gnt;
  logic            tie_pick1;
  logic            gnt0;
  logic            gnt1;
  logic            slot_free;
  logic            xfer;

  logic            out_valid_q;
  logic [DW-1:0]   out_res_q;
  logic [ID_W-1:0] out_id_q;

  logic [2:0]      sel_op;
  logic [DW-1:0]   sel_src1;
  logic [DW-1:0]   sel_src2;
  logic [DW-1:0]   core_res;

  // ---------------- grant ----------------
`ifdef YSYX_22041461_SHARB_RR_EN
  // On a tie the port that did not win last time goes first.
  assign tie_pick1 = ~last_gnt;
`else
  assign tie_pick1 = 1'b0;
`endif

  assign gnt1      = bus.in1_valid & (~bus.in0_valid | tie_pick1);
  assign gnt0      = bus.in0_valid & ~gnt1;
  assign slot_free = ~out_valid_q | bus.out_ready;

  // rst_n is folded in so both readies are low for the whole reset window.
  assign bus.in0_ready = gnt0 & slot_free & rst_n;
  assign bus.in1_ready = gnt1 & slot_free & rst_n;

  assign xfer = (gnt0 | gnt1) & slot_free;

  // ---------------- datapath ----------------
  always_comb begin
    sel_op   = bus.in0_op;
    sel_src1 = bus.in0_src1;
    sel_src2 = bus.in0_src2;
    if (gnt1) begin
      sel_op   = bus.in1_op;
      sel_src1 = bus.in1_src1;
      sel_src2 = bus.in1_src2;
    end
  end

  ysyx_22041461_shift_core #(.DW(DW)) u_core (
    .op   (sel_op),
    .src1 (sel_src1),
    .src2 (sel_src2),
    .res  (core_res)
  );

  // ---------------- arbitration state ----------------
  // Reset to 1 so that port 0 wins the first tie in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (xfer) begin
      last_gnt <= gnt1;
    end
  end

  // ---------------- result register ----------------
  // Refill takes priority over drain, so drain+refill in one cycle leaves
  // no bubble; a plain drain keeps res/id and only clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_id_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_res_q   <= core_res;
      out_id_q    <= gnt1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_id    = out_id_q;
  assign dbg_last_gnt  = last_gnt;

endmodule

// File: tb/tb_ysyx_22041461_shift_arb.sv
// Bench for ysyx_22041461_shift_arb: directed vectors, expected results
// queued at issue time, a negedge monitor that pops on each consumed result.
module tb_ysyx_22041461_shift_arb;
  import ysyx_22041461_shift_pkg::*;

  localparam int W = 65;  // {id, res}

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
  } req_t;

  logic clk;
  logic rst_n;
  logic dbg_last_gnt;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  req_t         q0[$];
  req_t         q1[$];

  int checks = 0;
  int errors = 0;

  ysyx_22041461_shift_arb_if #(.DW(64)) bus ();

  ysyx_22041461_shift_arb #(.DW(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_last_gnt (dbg_last_gnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((bus.in0_ready && bus.in1_ready) || (bus.in0_ready && !bus.in0_valid) ||
          (bus.in1_ready && !bus.in1_valid)) begin
        errors++;
        $display("FAIL ready_rules act r0=%0b r1=%0b v0=%0b v1=%0b", bus.in0_ready,
                 bus.in1_ready, bus.in0_valid, bus.in1_valid);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected act id=%0d res=%h req=none", bus.out_id, bus.out_res);
        end else begin
          exp_e = exp_q.pop_front();
          if ({bus.out_id, bus.out_res} !== exp_e) begin
            errors++;
            $display("FAIL out_result act id=%0d res=%h req id=%0d res=%h", bus.out_id,
                     bus.out_res, exp_e[64], exp_e[63:0]);
          end
        end
      end
    end else begin
      checks++;
      if (bus.in0_ready || bus.in1_ready) begin
        errors++;
        $display("FAIL ready_in_reset act r0=%0b r1=%0b req=0", bus.in0_ready, bus.in1_ready);
      end
    end
  end

  // Requester rule: a pending request keeps valid and payload until ready.
  logic         p0_pend, p1_pend;
  logic [130:0] p0_pl, p1_pl;
  always @(negedge clk) begin
    if (rst_n && p0_pend)
      assert (bus.in0_valid && {bus.in0_op, bus.in0_src1, bus.in0_src2} == p0_pl)
      else $error("requester rule broken on port 0");
    if (rst_n && p1_pend)
      assert (bus.in1_valid && {bus.in1_op, bus.in1_src1, bus.in1_src2} == p1_pl)
      else $error("requester rule broken on port 1");
    p0_pend <= rst_n && bus.in0_valid && !bus.in0_ready;
    p1_pend <= rst_n && bus.in1_valid && !bus.in1_ready;
    p0_pl   <= {bus.in0_op, bus.in0_src1, bus.in0_src2};
    p1_pl   <= {bus.in1_op, bus.in1_src1, bus.in1_src2};
  end

  // ---------------- helpers ----------------
  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0b req=%0b", name, act, req);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic id, input logic [63:0] r);
    exp_q.push_back({id, r});
  endtask

  // Drives both request queues until empty; entered and left at posedge+1.
  task automatic run_ports(input int budget);
    int   cyc;
    logic hs0, hs1;
    cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && cyc < budget) begin
      bus.in0_valid = (q0.size() != 0);
      if (q0.size() != 0) begin
        bus.in0_op   = q0[0].op;
        bus.in0_src1 = q0[0].s1;
        bus.in0_src2 = q0[0].s2;
      end
      bus.in1_valid = (q1.size() != 0);
      if (q1.size() != 0) begin
        bus.in1_op   = q1[0].op;
        bus.in1_src1 = q1[0].s1;
        bus.in1_src2 = q1[0].s2;
      end
      @(negedge clk);
      hs0 = bus.in0_valid && bus.in0_ready;
      hs1 = bus.in1_valid && bus.in1_ready;
      @(posedge clk);
      #1;
      if (hs0) q0.delete(0);
      if (hs1) q1.delete(0);
      cyc++;
    end
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL run_ports_budget act left0=%0d left1=%0d req=0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic send(input logic port, input logic [2:0] op, input logic [63:0] s1,
                      input logic [63:0] s2, input logic [63:0] r);
    push_exp(port, r);
    if (port) q1.push_back('{op: op, s1: s1, s2: s2});
    else      q0.push_back('{op: op, s1: s1, s2: s2});
    run_ports(20);
    chk1("latency_valid", bus.out_valid, 1'b1);
    chk1("latency_id", bus.out_id, port);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in0_valid = 1'b1;
    bus.in0_op    = OP_SRA;
    bus.in0_src1  = 64'h8000_0000_0000_0000;
    bus.in0_src2  = 64'd4;
    bus.in1_valid = 1'b1;
    bus.in1_op    = OP_SLL;
    bus.in1_src1  = 64'd1;
    bus.in1_src2  = 64'h45;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk64("rst_out_res", bus.out_res, 64'h0);
    chk1("rst_out_id", bus.out_id, 1'b0);
    chk1("rst_ready0", bus.in0_ready, 1'b0);
    chk1("rst_ready1", bus.in1_ready, 1'b0);
    chk1("rst_last_gnt", dbg_last_gnt, 1'b1);

    // Release with both requests pending: port 0 first (SRA), then port 1.
    rst_n = 1'b1;
    push_exp(1'b0, 64'hF800_0000_0000_0000);
    push_exp(1'b1, 64'h20);
    q0.push_back('{op: OP_SRA, s1: 64'h8000_0000_0000_0000, s2: 64'd4});
    q1.push_back('{op: OP_SLL, s1: 64'd1, s2: 64'h45});
    run_ports(20);

    // 64-bit boundaries on port 0.
    send(1'b0, OP_SLL, 64'd1, 64'd63, 64'h8000_0000_0000_0000);
    send(1'b0, OP_SRL, 64'hF000_0000_0000_0000, 64'd60, 64'hF);

    // Word ops and illegal codes on port 1.
    send(1'b1, OP_SRAW, 64'h0000_0000_8000_0000, 64'h21, 64'hFFFF_FFFF_C000_0000);
    send(1'b1, OP_SLLW, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000);
    send(1'b1, OP_SRLW, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000);
    send(1'b1, OP_SRLW, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000);
    send(1'b1, 3'b011, 64'h1234_5678_9ABC_DEF0, 64'd3, 64'h0);
    send(1'b1, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0);
    chk1("last_gnt_after_p1", dbg_last_gnt, 1'b1);

    // Tie arbitration: four requests on each port, all presented together.
    for (int k = 0; k < 4; k++) begin
      q0.push_back('{op: OP_SLL, s1: 64'd1, s2: 64'(k + 1)});
      q1.push_back('{op: OP_SRL, s1: 64'h100, s2: 64'(k + 1)});
    end
`ifdef YSYX_22041461_SHARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b0, 64'd2 << k);
      push_exp(1'b1, 64'h100 >> (k + 1));
    end
`else
    for (int k = 0; k < 4; k++) push_exp(1'b0, 64'd2 << k);
    for (int k = 0; k < 4; k++) push_exp(1'b1, 64'h100 >> (k + 1));
`endif
    run_ports(40);

    // Backpressure: load a result from port 1, then stall the consumer.
    push_exp(1'b1, 64'hFF);
    q1.push_back('{op: OP_SRL, s1: 64'hFF00, s2: 64'd8});
    run_ports(20);
    bus.out_ready = 1'b0;
    push_exp(1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    push_exp(1'b1, 64'h0000_0000_07FF_FFFF);
    bus.in0_valid = 1'b1;
    bus.in0_op    = OP_SRA;
    bus.in0_src1  = 64'hFFFF_FFFF_FFFF_FFF0;
    bus.in0_src2  = 64'd2;
    bus.in1_valid = 1'b1;
    bus.in1_op    = OP_SRAW;
    bus.in1_src1  = 64'h0000_0000_7FFF_FFFF;
    bus.in1_src2  = 64'd4;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk1("bp_out_valid", bus.out_valid, 1'b1);
      chk64("bp_out_res", bus.out_res, 64'hFF);
      chk1("bp_out_id", bus.out_id, 1'b1);
      chk1("bp_ready0", bus.in0_ready, 1'b0);
      chk1("bp_ready1", bus.in1_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk1("bp_refill_ready0", bus.in0_ready, 1'b1);
    @(posedge clk);
    #1;
    chk1("bp_no_bubble_valid", bus.out_valid, 1'b1);
    chk1("bp_no_bubble_id", bus.out_id, 1'b0);
    chk64("bp_no_bubble_res", bus.out_res, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.in0_valid = 1'b0;
    q1.push_back('{op: OP_SRAW, s1: 64'h0000_0000_7FFF_FFFF, s2: 64'd4});
    run_ports(20);

    // Let the last result drain, then load one that reset will discard.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    q0.push_back('{op: OP_SLL, s1: 64'd3, s2: 64'd1});
    run_ports(20);
    chk1("mr_loaded", bus.out_valid, 1'b1);
    bus.in0_valid = 1'b1;
    bus.in0_op    = OP_SRA;
    bus.in0_src1  = 64'h8000_0000_0000_0000;
    bus.in0_src2  = 64'd63;
    rst_n = 1'b0;
    #1;
    chk1("mr_out_valid", bus.out_valid, 1'b0);
    chk64("mr_out_res", bus.out_res, 64'h0);
    chk1("mr_ready0", bus.in0_ready, 1'b0);
    chk1("mr_ready1", bus.in1_ready, 1'b0);
    #4;
    bus.in0_valid = 1'b0;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk1("mr_no_stale", bus.out_valid, 1'b0);
    push_exp(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    q0.push_back('{op: OP_SRA, s1: 64'h8000_0000_0000_0000, s2: 64'd63});
    run_ports(20);
    chk1("mr_last_gnt", dbg_last_gnt, 1'b0);

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk1("queue_empty", exp_q.size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
